// File: rtl/vga_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : vga_pkg                                                    |
// | Description : Shared types for the VRAM arbiter slice: VGA phase codes,  |
// |               VRAM owner tags and the arbiter write-lock phase states.   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package vga_pkg;

    // Phase codes produced by the VGA timing generator for h_state/v_state.
    typedef enum logic [1:0] {
        PH_SYNC        = 2'd0,
        PH_BACK_PORCH  = 2'd1,
        PH_DISPLAY     = 2'd2,
        PH_FRONT_PORCH = 2'd3
    } vphase_t;

    // Owner of a VRAM slot; also the tag that routes returned read data.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_DISP = 2'd1,
        OWN_M0   = 2'd2,
        OWN_M1   = 2'd3
    } owner_t;

    // Write-lock phase: game-logic writes are only let through in VBLANK.
    typedef enum logic [0:0] {
        ARB_ACTIVE = 1'b0,
        ARB_VBLANK = 1'b1
    } arb_phase_t;

endpackage
`default_nettype wire

// File: rtl/vram_disp_addr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : vram_disp_addr                                             |
// | Description : Combinational display-slot detector. Flags the cycles in   |
// |               which the display pipe owns VRAM and forms the tile        |
// |               address for the column being prefetched.                   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   x, y              in   timing counters                                 |
// |   h_state, v_state  in   horizontal / vertical phase codes               |
// |   slot              out  1 = display fetch owns VRAM this cycle          |
// |   addr              out  tile address for that fetch                     |
// +--------------------------------------------------------------------------+
module vram_disp_addr
    import vga_pkg::*;
#(
    parameter int X_W        = 10,
    parameter int Y_W        = 9,
    parameter int ADDR_W     = 10,
    parameter int TILE_SHIFT = 3,
    parameter int COLS       = 28,
    parameter int PREFETCH_X = 40
) (
    input  logic [X_W-1:0]    x,
    input  logic [Y_W-1:0]    y,
    input  logic [1:0]        h_state,
    input  logic [1:0]        v_state,
    output logic              slot,
    output logic [ADDR_W-1:0] addr
);

    logic [X_W-1:0] w_col_next;
    logic [X_W-1:0] w_col;
    logic           w_in_disp;
    logic           w_in_bp;

    // Fetches run one tile ahead of the beam, so the column fetched at the
    // start of tile N is N+1; column 0 is fetched in the back porch instead.
    assign w_col_next = (x >> TILE_SHIFT) + X_W'(1);

    assign w_in_disp = (h_state == PH_DISPLAY) &&
                       (x[TILE_SHIFT-1:0] == '0) &&
                       (w_col_next < X_W'(COLS));
    assign w_in_bp   = (h_state == PH_BACK_PORCH) && (x == X_W'(PREFETCH_X));

    assign slot  = (v_state == PH_DISPLAY) && (w_in_disp || w_in_bp);
    assign w_col = w_in_disp ? w_col_next : '0;

    // Row-major tile map; result wraps to the VRAM address width.
    assign addr = ADDR_W'(y >> TILE_SHIFT) * ADDR_W'(COLS) + ADDR_W'(w_col);

endmodule
`default_nettype wire

// File: rtl/vram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : vram_arbiter                                               |
// | Description : Single-port tile RAM arbiter. Display fetches take fixed   |
// |               top priority, game logic (m0) and ghost AI (m1) share the  |
// |               remaining slots round-robin. m0 writes can be held until   |
// |               vertical blanking. Also emits a frame_start pulse.         |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk, rst_n           pixel clock, async active-low reset               |
// |   x, y, h/v_state      VGA timing inputs                                 |
// |   ram_addr/we/wdata    registered VRAM port; ram_rdata 1 cycle later     |
// |   disp_tile/valid      fetched tile for the display pipe                 |
// |   m0_*                 game-logic read/write requester                   |
// |   m1_*                 AI read requester                                 |
// |   m_rdata              read data shared by m0/m1, qualified by rvalid    |
// |   frame_start          1-cycle pulse when v_state enters SYNC            |
// +--------------------------------------------------------------------------+
module vram_arbiter
    import vga_pkg::*;
#(
    parameter int X_W        = 10,
    parameter int Y_W        = 9,
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 4,
    parameter int TILE_SHIFT = 3,
    parameter int COLS       = 28,
    parameter int PREFETCH_X = 40,
    parameter bit LOCK_WR    = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [X_W-1:0]    x,
    input  logic [Y_W-1:0]    y,
    input  logic [1:0]        h_state,
    input  logic [1:0]        v_state,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] disp_tile,
    output logic              disp_valid,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m_rdata,
    output logic              frame_start
);

    arb_phase_t r_phase;
    owner_t     r_rr_ptr;   // requester that wins the next m0/m1 tie
    owner_t     r_tag0;     // owner of the access issued on the port now
    owner_t     r_tag1;     // owner whose read data is on ram_rdata now
    logic [1:0] r_v_prev;

    logic              w_disp_slot;
    logic [ADDR_W-1:0] w_disp_addr;
    logic              w_m0_elig;
    logic              w_m1_elig;
    owner_t            w_owner;

    vram_disp_addr #(
        .X_W        (X_W),
        .Y_W        (Y_W),
        .ADDR_W     (ADDR_W),
        .TILE_SHIFT (TILE_SHIFT),
        .COLS       (COLS),
        .PREFETCH_X (PREFETCH_X)
    ) u_disp_addr (
        .x       (x),
        .y       (y),
        .h_state (h_state),
        .v_state (v_state),
        .slot    (w_disp_slot),
        .addr    (w_disp_addr)
    );

    // Reads from m0 are never locked; only its writes wait for blanking.
    assign w_m0_elig = m0_req && (!m0_we || !LOCK_WR || (r_phase == ARB_VBLANK));
    assign w_m1_elig = m1_req;

    always_comb begin
        w_owner = OWN_NONE;
        if (w_disp_slot) begin
            w_owner = OWN_DISP;
        end else if (w_m0_elig && w_m1_elig) begin
            w_owner = r_rr_ptr;
        end else if (w_m0_elig) begin
            w_owner = OWN_M0;
        end else if (w_m1_elig) begin
            w_owner = OWN_M1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase     <= ARB_ACTIVE;
            r_rr_ptr    <= OWN_M0;
            r_tag0      <= OWN_NONE;
            r_tag1      <= OWN_NONE;
            r_v_prev    <= PH_SYNC;
            ram_addr    <= '0;
            ram_we      <= 1'b0;
            ram_wdata   <= '0;
            disp_tile   <= '0;
            disp_valid  <= 1'b0;
            m0_gnt      <= 1'b0;
            m0_rvalid   <= 1'b0;
            m1_gnt      <= 1'b0;
            m1_rvalid   <= 1'b0;
            m_rdata     <= '0;
            frame_start <= 1'b0;
        end else begin
            // Write-lock phase tracking
            case (r_phase)
                ARB_ACTIVE: if (v_state != PH_DISPLAY) r_phase <= ARB_VBLANK;
                ARB_VBLANK: if (v_state == PH_DISPLAY) r_phase <= ARB_ACTIVE;
                default:    r_phase <= ARB_ACTIVE;
            endcase

            // Issue stage: drive the RAM port for this cycle's owner
            m0_gnt <= (w_owner == OWN_M0);
            m1_gnt <= (w_owner == OWN_M1);
            ram_we <= (w_owner == OWN_M0) && m0_we;
            case (w_owner)
                OWN_DISP: ram_addr <= w_disp_addr;
                OWN_M0: begin
                    ram_addr <= m0_addr;
                    if (m0_we) ram_wdata <= m0_wdata;
                end
                OWN_M1:   ram_addr <= m1_addr;
                default:  ;
            endcase

            // Display slots leave the round-robin pointer untouched.
            if (w_owner == OWN_M0) r_rr_ptr <= OWN_M1;
            else if (w_owner == OWN_M1) r_rr_ptr <= OWN_M0;

            // Writes return nothing, so they enter the tag pipe as NONE.
            r_tag0 <= ((w_owner == OWN_M0) && m0_we) ? OWN_NONE : w_owner;
            r_tag1 <= r_tag0;

            // Return stage: route ram_rdata by the tag that issued it
            disp_valid <= (r_tag1 == OWN_DISP);
            m0_rvalid  <= (r_tag1 == OWN_M0);
            m1_rvalid  <= (r_tag1 == OWN_M1);
            if (r_tag1 == OWN_DISP) disp_tile <= ram_rdata;
            if ((r_tag1 == OWN_M0) || (r_tag1 == OWN_M1)) m_rdata <= ram_rdata;

            r_v_prev    <= v_state;
            frame_start <= (v_state == PH_SYNC) && (r_v_prev != PH_SYNC);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_vram_arbiter                                            |
// | Description : Self-checking bench for vram_arbiter. A behavioural model  |
// |               (slot rule, priority, round-robin, return schedule queue,  |
// |               reference memory) predicts every output each cycle.        |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_vram_arbiter;

    localparam int X_W        = 10;
    localparam int Y_W        = 9;
    localparam int ADDR_W     = 10;
    localparam int DATA_W     = 4;
    localparam int COLS       = 28;
    localparam int PREFETCH_X = 40;
    localparam int DEPTH      = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [X_W-1:0]    x = '0;
    logic [Y_W-1:0]    y = '0;
    logic [1:0]        h_state = 2'd0;
    logic [1:0]        v_state = 2'd0;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] disp_tile;
    logic              disp_valid;
    logic              m0_req = 1'b0;
    logic              m0_we = 1'b0;
    logic [ADDR_W-1:0] m0_addr = '0;
    logic [DATA_W-1:0] m0_wdata = '0;
    logic              m0_gnt;
    logic              m0_rvalid;
    logic              m1_req = 1'b0;
    logic [ADDR_W-1:0] m1_addr = '0;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [DATA_W-1:0] m_rdata;
    logic              frame_start;

    vram_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .x           (x),
        .y           (y),
        .h_state     (h_state),
        .v_state     (v_state),
        .ram_addr    (ram_addr),
        .ram_we      (ram_we),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .disp_tile   (disp_tile),
        .disp_valid  (disp_valid),
        .m0_req      (m0_req),
        .m0_we       (m0_we),
        .m0_addr     (m0_addr),
        .m0_wdata    (m0_wdata),
        .m0_gnt      (m0_gnt),
        .m0_rvalid   (m0_rvalid),
        .m1_req      (m1_req),
        .m1_addr     (m1_addr),
        .m1_gnt      (m1_gnt),
        .m1_rvalid   (m1_rvalid),
        .m_rdata     (m_rdata),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Single-port synchronous VRAM, read-old on a same-edge write.
    logic [DATA_W-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    // ---------------- reference model state ----------------
    typedef struct {
        int                due;   // cycle at which the strobe is expected
        int                kind;  // 1 display, 2 m0, 3 m1
        logic [DATA_W-1:0] data;
    } ret_t;

    logic [DATA_W-1:0] ref_mem [DEPTH];
    ret_t              retq[$];
    int                cyc = 0;
    int                last_owner = 0;   // 0 none, 1 disp, 2 m0, 3 m1
    bit                mdl_rr_m1 = 1'b0; // next m0/m1 tie goes to m1
    bit                mdl_wr_ok = 1'b0; // v_state was outside DISPLAY last edge
    int                mdl_v_prev = 0;
    bit                pend_wr = 1'b0;
    int                pend_addr = 0;
    logic [DATA_W-1:0] pend_data = '0;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Display slot rule: returns the tile column fetched, or -1 for no slot.
    function automatic int disp_col(input int xx, input int hh, input int vv);
        if (vv != 2) return -1;
        if (hh == 2 && (xx % 8) == 0 && (xx / 8 + 1) < COLS) return xx / 8 + 1;
        if (hh == 1 && xx == PREFETCH_X) return 0;
        return -1;
    endfunction

    // One clock edge: predict and check every output, then advance the model.
    task automatic step();
        int                col, own, addr;
        bit                e0, e1, exp_dv, exp_r0, exp_r1, exp_fs;
        logic [DATA_W-1:0] exp_data;
        ret_t              r;
        @(posedge clk);
        #1;
        cyc++;
        last_owner = 0;
        if (!rst_n) begin
            retq.delete();
            pend_wr    = 1'b0;
            mdl_rr_m1  = 1'b0;
            mdl_wr_ok  = 1'b0;
            mdl_v_prev = 0;
            check_eq("reset_outs",
                     32'({ram_addr, ram_we, ram_wdata, disp_tile, disp_valid, m0_gnt,
                          m0_rvalid, m1_gnt, m1_rvalid, m_rdata, frame_start}), 32'd0);
            return;
        end
        // A write granted last edge lands in RAM on this edge.
        if (pend_wr) ref_mem[pend_addr] = pend_data;
        pend_wr = 1'b0;

        exp_dv = 0; exp_r0 = 0; exp_r1 = 0; exp_data = '0;
        if (retq.size() > 0 && retq[0].due == cyc) begin
            r = retq.pop_front();
            exp_dv = (r.kind == 1);
            exp_r0 = (r.kind == 2);
            exp_r1 = (r.kind == 3);
            exp_data = r.data;
        end
        check_eq("disp_valid", 32'(disp_valid), 32'(exp_dv));
        check_eq("m0_rvalid", 32'(m0_rvalid), 32'(exp_r0));
        check_eq("m1_rvalid", 32'(m1_rvalid), 32'(exp_r1));
        if (exp_dv) check_eq("disp_tile", 32'(disp_tile), 32'(exp_data));
        if (exp_r0 || exp_r1) check_eq("m_rdata", 32'(m_rdata), 32'(exp_data));

        col = disp_col(int'(x), int'(h_state), int'(v_state));
        e0  = m0_req && (!m0_we || mdl_wr_ok);
        e1  = m1_req;
        if (col >= 0)      own = 1;
        else if (e0 && e1) own = mdl_rr_m1 ? 3 : 2;
        else if (e0)       own = 2;
        else if (e1)       own = 3;
        else               own = 0;

        check_eq("m0_gnt", 32'(m0_gnt), 32'(own == 2));
        check_eq("m1_gnt", 32'(m1_gnt), 32'(own == 3));
        check_eq("ram_we", 32'(ram_we), 32'(own == 2 && m0_we));

        addr = 0;
        if (own == 1) addr = ((int'(y) / 8) * COLS + col) % DEPTH;
        if (own == 2) addr = int'(m0_addr);
        if (own == 3) addr = int'(m1_addr);
        if (own != 0) check_eq("ram_addr", 32'(ram_addr), 32'(addr));

        if (own == 2 && m0_we) begin
            check_eq("ram_wdata", 32'(ram_wdata), 32'(m0_wdata));
            pend_wr = 1'b1; pend_addr = addr; pend_data = m0_wdata;
        end else if (own != 0) begin
            r.due = cyc + 2; r.kind = own; r.data = ref_mem[addr];
            retq.push_back(r);
        end
        if (own == 2) mdl_rr_m1 = 1'b1;
        if (own == 3) mdl_rr_m1 = 1'b0;

        exp_fs = (v_state == 2'd0) && (mdl_v_prev != 0);
        check_eq("frame_start", 32'(frame_start), 32'(exp_fs));
        mdl_v_prev = int'(v_state);
        mdl_wr_ok  = (v_state != 2'd2);
        last_owner = own;
    endtask

    // Random requesters: hold req until granted, then drop or re-present.
    task automatic drive_agents();
        bit n0, n1;
        n0 = 0; n1 = 0;
        if (!m0_req || last_owner == 2) begin
            m0_req = ($urandom_range(0, 2) == 0);
            n0 = m0_req;
        end
        if (n0) begin
            m0_we    = 1'($urandom_range(0, 1));
            m0_addr  = ADDR_W'($urandom_range(0, 63));
            m0_wdata = DATA_W'($urandom_range(0, 15));
        end
        if (!m1_req || last_owner == 3) begin
            m1_req = ($urandom_range(0, 2) == 0);
            n1 = m1_req;
        end
        if (n1) m1_addr = ADDR_W'($urandom_range(0, 63));
    endtask

    task automatic drive_timing();
        if ($urandom_range(0, 15) == 0) v_state = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0)  h_state = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 3))
            0:       x = X_W'(PREFETCH_X);
            1, 2:    x = X_W'(8 * $urandom_range(0, 31));
            default: x = X_W'($urandom_range(0, 799));
        endcase
        if ($urandom_range(0, 7) == 0) y = Y_W'($urandom_range(0, 287));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [DATA_W-1:0] v;
        bit                seen;
        for (int i = 0; i < DEPTH; i++) begin
            v = DATA_W'($urandom_range(0, 15));
            ram[i] <= v;
            ref_mem[i] = v;
        end

        // 1: reset held with an m0 read pending, then release
        m0_req = 1; m0_we = 0; m0_addr = 10'd5;
        repeat (3) step();
        rst_n = 1;
        step();
        check_eq("t1_gnt_first_edge", 32'(m0_gnt), 32'd1);
        m0_req = 0;
        step();
        step();
        check_eq("t1_rvalid_2_later", 32'(m0_rvalid), 32'd1);

        // 2: both reads held continuously in blanking
        m0_req = 1; m0_addr = 10'd11; m1_req = 1; m1_addr = 10'd12;
        repeat (6) begin
            step();
            check_eq("t2_one_grant", 32'(m0_gnt) + 32'(m1_gnt), 32'd1);
        end
        m0_req = 0; m1_req = 0;
        repeat (3) step();

        // 3: display fetch at y=16, x=8
        v_state = 2'd2; h_state = 2'd2; y = 9'd16; x = 10'd8;
        step();
        check_eq("t3_addr", 32'(ram_addr), 32'd58);
        h_state = 2'd3;
        step();
        step();
        check_eq("t3_disp_valid", 32'(disp_valid), 32'd1);
        check_eq("t3_disp_tile", 32'(disp_tile), 32'(ref_mem[58]));

        // 4: locked write during DISPLAY, released by front porch
        x = 10'd500;
        m0_req = 1; m0_we = 1; m0_addr = 10'd100; m0_wdata = 4'd7;
        repeat (4) begin
            step();
            check_eq("t4_locked", 32'(m0_gnt), 32'd0);
        end
        v_state = 2'd3;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (m0_gnt) begin
                seen = 1;
                break;
            end
        end
        check_eq("t4_gnt_seen", 32'(seen), 32'd1);
        m0_req = 0;
        step();
        m0_req = 1; m0_we = 0;
        step();
        m0_req = 0;
        step();
        step();
        check_eq("t4_readback", 32'(m_rdata), 32'd7);

        // 5: m1 request colliding with a display slot
        v_state = 2'd2; h_state = 2'd2; y = 9'd0; x = 10'd16;
        m1_req = 1; m1_addr = 10'd200;
        step();
        check_eq("t5_deferred", 32'(m1_gnt), 32'd0);
        x = 10'd17;
        step();
        check_eq("t5_gnt", 32'(m1_gnt), 32'd1);
        m1_req = 0;
        step();
        step();
        check_eq("t5_m1_rvalid", 32'(m1_rvalid), 32'd1);
        check_eq("t5_m1_data", 32'(m_rdata), 32'(ref_mem[200]));

        // 6: frame_start pulse and reset between grant and return
        v_state = 2'd3;
        step();
        v_state = 2'd0;
        step();
        check_eq("t6_frame_start", 32'(frame_start), 32'd1);
        step();
        check_eq("t6_frame_single", 32'(frame_start), 32'd0);
        m0_req = 1; m0_we = 0; m0_addr = 10'd33;
        step();
        m0_req = 0;
        rst_n = 0;
        step();
        rst_n = 1;
        step();
        check_eq("t6_no_rvalid", 32'(m0_rvalid), 32'd0);
        step();

        // Randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            drive_timing();
            drive_agents();
            if (!rst_n) rst_n = 1;
            else if ($urandom_range(0, 499) == 0) rst_n = 0;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
